// File: rtl/repvgg_line_buf.sv
// repvgg_line_buf: 3x3 sliding-window line buffer for raster-order pixel streams.
//   Two MAX_W-deep line memories hold the previous two rows; per-row column
//   shift registers supply the two left columns of the window.
//   Ports: clk, rst (async, active-high); start/cfg_w/cfg_h/cfg_stride frame
//   control; busy, done (one-cycle end-of-frame pulse); in_valid/in_ready/in_data
//   pixel input; out_valid/out_ready/out_data/out_last window output, where
//   window position k = 3*row + col (row 0 oldest) sits at out_data[k*CH*DATA_W +: CH*DATA_W].
//   Optional macro REPVGG_LB_STRIDE2_EN enables stride-2 selection via cfg_stride;
//   without it cfg_stride is ignored and the block is stride 1 only.
module repvgg_line_buf #(
  parameter int DATA_W = 8,
  parameter int CH     = 4,
  parameter int MAX_W  = 64,
  parameter int W_BITS = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [W_BITS-1:0]      cfg_w,
  input  logic [15:0]            cfg_h,
  input  logic                   cfg_stride,
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH*DATA_W-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [9*CH*DATA_W-1:0] out_data,
  output logic                   out_last
);
  localparam int PW = CH * DATA_W;
  localparam int AW = $clog2(MAX_W);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0] state;
  logic [W_BITS-1:0] w_r, col;
  logic [15:0] h_r, row;
  logic [PW-1:0] lb0 [MAX_W];
  logic [PW-1:0] lb1 [MAX_W];
  logic [PW-1:0] t1, t2, m1, m2, b1, b2, top, mid;
  logic cfg_ok, acc, last_px, emit, win_last, hs_last, fin_now;
  assign busy     = state != IDLE;
  assign in_ready = state == RUN && (!out_valid || out_ready);
  assign acc      = in_valid && in_ready;
  assign cfg_ok   = cfg_w >= W_BITS'(3) && cfg_w <= W_BITS'(MAX_W) && cfg_h >= 16'd3;
  assign top      = lb0[col[AW-1:0]];
  assign mid      = lb1[col[AW-1:0]];
  assign last_px  = row == h_r - 16'd1 && col == w_r - W_BITS'(1);
  assign hs_last  = out_valid && out_ready && out_last;
`ifdef REPVGG_LB_STRIDE2_EN
  logic stride_r, fin;
  logic [15:0] lr;
  logic [W_BITS-1:0] lc;
  // With stride 2 the final window sits on the last even row/column, which can
  // precede the final pixel; fin remembers that its handshake already happened.
  assign lr       = stride_r ? ((h_r - 16'd1) & ~16'd1) : h_r - 16'd1;
  assign lc       = stride_r ? ((w_r - W_BITS'(1)) & ~W_BITS'(1)) : w_r - W_BITS'(1);
  assign emit     = row >= 16'd2 && col >= W_BITS'(2) && (!stride_r || (!row[0] && !col[0]));
  assign win_last = row == lr && col == lc;
  assign fin_now  = fin || hs_last;
`else
  logic unused_stride;
  assign unused_stride = cfg_stride;
  assign emit     = row >= 16'd2 && col >= W_BITS'(2);
  assign win_last = last_px;
  assign fin_now  = hs_last;
`endif
  // Line memories rotate per column: row r-1 moves up to r-2, the new pixel becomes r-1.
  always_ff @(posedge clk)
    if (acc) begin
      lb0[col[AW-1:0]] <= mid;
      lb1[col[AW-1:0]] <= in_data;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      w_r       <= '0;
      h_r       <= '0;
      col       <= '0;
      row       <= '0;
      t1        <= '0;
      t2        <= '0;
      m1        <= '0;
      m2        <= '0;
      b1        <= '0;
      b2        <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
`ifdef REPVGG_LB_STRIDE2_EN
      stride_r  <= 1'b0;
      fin       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef REPVGG_LB_STRIDE2_EN
      if (hs_last) fin <= 1'b1;
`endif
      case (state)
        IDLE:
          if (start) begin
            if (cfg_ok) begin
              state <= RUN;
              w_r   <= cfg_w;
              h_r   <= cfg_h;
              row   <= '0;
              col   <= '0;
`ifdef REPVGG_LB_STRIDE2_EN
              stride_r <= cfg_stride;
              fin      <= 1'b0;
`endif
            end else done <= 1'b1;
          end
        RUN:
          if (acc && last_px) state <= DRAIN;
        DRAIN:
          if (fin_now) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        default: state <= IDLE;
      endcase
      if (acc) begin
        col <= col == w_r - W_BITS'(1) ? '0 : col + W_BITS'(1);
        row <= col == w_r - W_BITS'(1) ? row + 16'd1 : row;
        t2  <= t1;
        t1  <= top;
        m2  <= m1;
        m1  <= mid;
        b2  <= b1;
        b1  <= in_data;
        out_valid <= emit;
        if (emit) begin
          out_data <= {in_data, b1, b2, mid, m1, m2, top, t1, t2};
          out_last <= win_last;
        end
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: doc/repvgg_line_buf.md
REPVGG_LINE_BUF -- requirements
Module: repvgg_line_buf

Interface
REQ-001 Parameters SHALL be as follows:
  DATA_W, 8, bits per channel sample.
  CH, 4, channels packed per pixel.
  MAX_W, 64, maximum image width in pixels.
  W_BITS, 7, width of cfg_w; SHALL hold MAX_W.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
  clk  in  1  single clock, rising edge.
  rst  in  1  asynchronous, active-high reset.
  start  in  1  frame start pulse.
  cfg_w  in  W_BITS  image width.
  cfg_h  in  16  image height.
  cfg_stride  in  1  0 = stride 1, 1 = stride 2.
  busy  out  1  frame in progress.
  done  out  1  one-cycle end-of-frame pulse.
  in_valid  in  1  input pixel valid.
  in_ready  out  1  input pixel accepted when in_valid && in_ready.
  in_data  in  CH*DATA_W  raster-order pixel.
  out_valid  out  1  window valid.
  out_ready  in  1  downstream ready.
  out_data  out  9*CH*DATA_W  3x3 window.
  out_last  out  1  final window of the frame.

Function
REQ-003 Window position k = 3*r + c: r = 0 is the oldest row, c = 0 is the leftmost column; position k SHALL occupy bits [(k+1)*CH*DATA_W-1 : k*CH*DATA_W].
REQ-004 The block SHALL have the states IDLE, RUN and DRAIN.
  IDLE -> RUN on start with valid cfg.
  RUN -> DRAIN when the last pixel (row cfg_h-1, column cfg_w-1) is accepted.
  DRAIN -> IDLE on the out_last handshake.
REQ-005 On start in IDLE, the block SHALL latch cfg_w, cfg_h and cfg_stride; start SHALL be ignored in RUN and DRAIN.
REQ-006 A cfg is invalid when cfg_w < 3, cfg_w > MAX_W or cfg_h < 3. With invalid cfg, the block SHALL stay in IDLE, pulse done the following cycle, and accept no pixels.
REQ-007 busy SHALL equal (state != IDLE).
REQ-008 in_ready SHALL equal RUN && (!out_valid || out_ready).
REQ-009 Two line memories of MAX_W pixels SHALL hold the previous two rows. Column and row counters SHALL advance per accepted pixel. The column counter SHALL wrap at cfg_w-1 and increment the row counter.
REQ-010 Accepting pixel (row, col) SHALL load a window, with out_valid asserted the next cycle, iff row >= 2 and col >= 2 (stride 1), or additionally row and col are both even (stride 2). The window has that pixel as its bottom-right element.
REQ-011 While out_valid && !out_ready, out_data and out_last SHALL hold stable and no input SHALL be accepted.
REQ-012 A simultaneous output handshake and input acceptance SHALL load the new window in the same cycle, sustaining one pixel per cycle.
REQ-013 Windows per frame SHALL be (cfg_h-2)*(cfg_w-2) for stride 1, or floor((cfg_h-1)/2)*floor((cfg_w-1)/2) for stride 2.
REQ-014 done SHALL pulse for exactly one cycle, the cycle after the out_last handshake.
REQ-015 A start arriving in the same cycle as the done pulse SHALL be honoured.

Reset
REQ-016 rst SHALL asynchronously clear the following: state = IDLE; busy, done, out_valid, out_last, in_ready = 0; out_data = 0; all counters = 0.
REQ-017 Line memory contents need not be reset.
REQ-018 Reset mid-frame SHALL discard the frame. The first frame after reset release SHALL be unaffected by prior contents.

Configuration
REQ-019 Macro REPVGG_LB_STRIDE2_EN.
  Defined: cfg_stride SHALL select behaviour per REQ-010 and REQ-013.
  Undefined: cfg_stride SHALL be ignored, behaviour SHALL be stride 1 only, and stride-2 logic SHALL be absent.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
  cfg_w=4, cfg_h=4, stride 1, pixels 0..15 streamed, out_ready=1 -> 4 windows. First window is 0,1,2,4,5,6,8,9,10. out_last on the 4th. done one cycle after.
  cfg_w=5, cfg_h=5, stride 2 (macro defined) -> 4 windows with top-left pixels 0,2,10,12.
  Same as scenario 1, but out_ready held 0 for 5 cycles at the first window -> out_data stable, in_ready=0 throughout, no pixel lost, identical window sequence.
  start with cfg_w=2 -> no in_ready, done pulse next cycle, busy stays 0.
  rst asserted after 7 pixels of a 4x4 frame, then a new 4x4 frame -> outputs clear immediately, and the new frame produces the correct 4 windows.
  cfg_w=MAX_W, cfg_h=3 with continuous valid -> MAX_W-2 windows at one per cycle after pixel 2*MAX_W+2.
